// File: rtl/crypto_csr_ctrl.sv
// rtl/crypto_csr_ctrl.sv - crypto coprocessor CSR block and engine sequencer
module crypto_csr_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic        write,
    input  logic [4:0]  write_addrs,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_strobe,
    output logic        write_error,
    output logic        write_done,
    input  logic        read,
    input  logic [4:0]  read_addrs,
    output logic [31:0] read_data,
    output logic        read_error,
    output logic        read_done,
    output logic        eng_start,
    output logic        eng_abort,
    output logic [63:0] eng_din,
    input  logic        eng_done,
    input  logic [63:0] eng_dout,
    output logic        irq
);
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_RUN   = 2'd1;
    localparam logic [1:0]  ST_ABORT = 2'd2;
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [31:0] din0_q, din0_d;
    logic [31:0] din1_q, din1_d;
    logic [31:0] dout0_q, dout0_d;
    logic [31:0] dout1_q, dout1_d;
    logic [15:0] cycles_q, cycles_d;

    logic [2:0]  wsel, rsel;
    logic        busy, wr_err, wr_ok, start_acc;

    assign wsel = write_addrs[4:2];
    assign rsel = read_addrs[4:2];
    assign busy = (state_q != ST_IDLE);

    // Write decode: read-only targets always reject; engine inputs are frozen while busy
    always_comb begin
        wr_err = 1'b0;
        case (wsel)
            3'd0:    wr_err = busy & write_strobe[0] & write_data[0];
            3'd2,
            3'd3:    wr_err = busy;
            3'd4,
            3'd5,
            3'd6,
            3'd7:    wr_err = 1'b1;
            default: wr_err = 1'b0;
        endcase
    end

    assign wr_ok       = write & ~wr_err;
    assign start_acc   = wr_ok & (wsel == 3'd0) & write_strobe[0] & write_data[0];
    assign write_done  = write;
    assign write_error = write & wr_err;

    // Sequencer state register
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) state_q <= ST_IDLE;
        else                state_q <= state_d;
    end

    // Sequencer next state: completion beats timeout on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_acc) state_d = ST_RUN;
            ST_RUN: begin
                if (eng_done)                 state_d = ST_IDLE;
                else if (cycles_q == TO_LAST) state_d = ST_ABORT;
            end
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sequencer outputs: the first RUN cycle is the only one with a zero count
    always_comb begin
        eng_start = (state_q == ST_RUN) && (cycles_q == 16'd0);
        eng_abort = (state_q == ST_ABORT);
    end

    // Register next values; hardware sets of DONE are applied last so they beat W1C
    always_comb begin
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        din0_d    = din0_q;
        din1_d    = din1_q;
        dout0_d   = dout0_q;
        dout1_d   = dout1_q;
        cycles_d  = cycles_q;
        if (wr_ok && wsel == 3'd0 && write_strobe[0]) irq_en_d = write_data[1];
        if (wr_ok && wsel == 3'd1 && write_strobe[0]) begin
            if (write_data[1]) done_d    = 1'b0;
            if (write_data[2]) timeout_d = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            if (wr_ok && wsel == 3'd2 && write_strobe[b]) din0_d[8*b +: 8] = write_data[8*b +: 8];
            if (wr_ok && wsel == 3'd3 && write_strobe[b]) din1_d[8*b +: 8] = write_data[8*b +: 8];
        end
        if (start_acc) begin
            cycles_d  = 16'd0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end
        if (state_q == ST_RUN && cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
        if (state_q == ST_RUN && eng_done) begin
            dout0_d = eng_dout[31:0];
            dout1_d = eng_dout[63:32];
            done_d  = 1'b1;
        end
        if (state_q == ST_ABORT) begin
            done_d    = 1'b1;
            timeout_d = 1'b1;
        end
    end

    // Register file storage
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            din0_q    <= 32'd0;
            din1_q    <= 32'd0;
            dout0_q   <= 32'd0;
            dout1_q   <= 32'd0;
            cycles_q  <= 16'd0;
        end else begin
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            din0_q    <= din0_d;
            din1_q    <= din1_d;
            dout0_q   <= dout0_d;
            dout1_q   <= dout1_d;
            cycles_q  <= cycles_d;
        end
    end

    // Read mux, zero when no read is presented
    always_comb begin
        read_data  = 32'd0;
        read_error = 1'b0;
        if (read) begin
            case (rsel)
                3'd0:    read_data = {30'd0, irq_en_q, 1'b0};
                3'd1:    read_data = {29'd0, timeout_q, done_q, busy};
                3'd2:    read_data = din0_q;
                3'd3:    read_data = din1_q;
                3'd4:    read_data = dout0_q;
                3'd5:    read_data = dout1_q;
                3'd6:    read_data = {16'd0, cycles_q};
                default: read_error = 1'b1;
            endcase
        end
    end

    assign read_done = read;
    assign eng_din   = {din1_q, din0_q};
    assign irq       = irq_en_q & done_q;
endmodule

// File: tb/tb_crypto_csr_ctrl.sv
// tb/tb_crypto_csr_ctrl.sv - directed self-checking bench for crypto_csr_ctrl
module tb_crypto_csr_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  write_addrs = '0;
    logic [31:0] write_data = '0;
    logic [3:0]  write_strobe = '0;
    logic        write_error, write_done;
    logic        read = 1'b0;
    logic [4:0]  read_addrs = '0;
    logic [31:0] read_data;
    logic        read_error, read_done;
    logic        eng_start, eng_abort;
    logic [63:0] eng_din;
    logic        eng_done = 1'b0;
    logic [63:0] eng_dout = '0;
    logic        irq;

    int total = 0;
    int bad = 0;

    crypto_csr_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .write(write), .write_addrs(write_addrs), .write_data(write_data),
        .write_strobe(write_strobe), .write_error(write_error), .write_done(write_done),
        .read(read), .read_addrs(read_addrs), .read_data(read_data),
        .read_error(read_error), .read_done(read_done),
        .eng_start(eng_start), .eng_abort(eng_abort), .eng_din(eng_din),
        .eng_done(eng_done), .eng_dout(eng_dout), .irq(irq)
    );

    always #5 clk = ~clk;

    // All tasks start and end 1ns after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic e);
        write = 1'b1; write_addrs = a; write_data = d; write_strobe = s;
        #2;
        e = write_error;
        step();
        write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic e);
        read = 1'b1; read_addrs = a;
        #2;
        d = read_data;
        e = read_error;
        step();
        read = 1'b0;
    endtask

    task automatic test_reset();
        logic e;
        logic [31:0] d;
        #1;
        total++; if ({eng_start, eng_abort, irq, eng_din} !== 67'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", {eng_start, eng_abort, irq, eng_din}); end
        step();
        rst_n = 1'b1;
        wr(5'h08, 32'hFFFFFFFF, 4'hF, e);
        wr(5'h00, 32'h3, 4'hF, e);
        total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL pre_reset_start got=%b want=1", eng_start); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if ({eng_start, eng_abort, irq, eng_din} !== 67'd0) begin bad++; $display("FAIL async_reset_outputs got=%h want=0", {eng_start, eng_abort, irq, eng_din}); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rd(5'(i * 4), d, e);
            total++; if (d !== 32'd0 || e !== 1'b0) begin bad++; $display("FAIL reset_reg%0d got=%h err=%b want=0", i, d, e); end
        end
        total++; if (eng_abort !== 1'b0) begin bad++; $display("FAIL reset_no_abort got=%b want=0", eng_abort); end
    endtask

    task automatic test_din();
        logic e;
        wr(5'h08, 32'h11223344, 4'b0101, e);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL din0_err got=%b want=0", e); end
        wr(5'h0C, 32'hAABBCCDD, 4'hF, e);
        total++; if (eng_din !== 64'hAABBCCDD_00220044) begin bad++; $display("FAIL eng_din got=%h want=aabbccdd00220044", eng_din); end
    endtask

    task automatic test_operation();
        logic e;
        logic [31:0] d;
        wr(5'h00, 32'h3, 4'hF, e);
        total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL op_start got=%b want=1", eng_start); end
        for (int k = 1; k <= 5; k++) begin
            step();
            total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL op_start_once k=%0d got=%b want=0", k, eng_start); end
        end
        eng_done = 1'b1; eng_dout = 64'h01234567_89ABCDEF;
        step();
        eng_done = 1'b0; eng_dout = '0;
        rd(5'h10, d, e);
        total++; if (d !== 32'h89ABCDEF) begin bad++; $display("FAIL op_dout0 got=%h want=89abcdef", d); end
        rd(5'h14, d, e);
        total++; if (d !== 32'h01234567) begin bad++; $display("FAIL op_dout1 got=%h want=01234567", d); end
        rd(5'h04, d, e);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL op_status got=%h want=2", d); end
        rd(5'h18, d, e);
        total++; if (d !== 32'd6) begin bad++; $display("FAIL op_cycles got=%0d want=6", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL op_irq got=%b want=1", irq); end
        wr(5'h04, 32'h2, 4'h1, e);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL op_irq_clear got=%b want=0", irq); end
    endtask

    task automatic test_timeout();
        logic e;
        logic [31:0] d;
        wr(5'h00, 32'h1, 4'hF, e);
        for (int k = 0; k < 8; k++) begin
            total++; if (eng_abort !== 1'b0) begin bad++; $display("FAIL to_early_abort k=%0d got=%b want=0", k, eng_abort); end
            step();
        end
        total++; if (eng_abort !== 1'b1) begin bad++; $display("FAIL to_abort got=%b want=1", eng_abort); end
        step();
        total++; if (eng_abort !== 1'b0) begin bad++; $display("FAIL to_abort_once got=%b want=0", eng_abort); end
        rd(5'h04, d, e);
        total++; if (d !== 32'h6) begin bad++; $display("FAIL to_status got=%h want=6", d); end
        rd(5'h10, d, e);
        total++; if (d !== 32'h89ABCDEF) begin bad++; $display("FAIL to_dout0 got=%h want=89abcdef", d); end
    endtask

    task automatic test_busy_reject();
        logic e;
        logic [31:0] d;
        read = 1'b1; read_addrs = 5'h04;
        write = 1'b1; write_addrs = 5'h00; write_data = 32'h1; write_strobe = 4'hF;
        #2;
        total++; if (read_data !== 32'h6) begin bad++; $display("FAIL start_edge_status got=%h want=6", read_data); end
        step();
        read = 1'b0; write = 1'b0;
        wr(5'h08, 32'hFFFFFFFF, 4'hF, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL busy_din0_err got=%b want=1", e); end
        wr(5'h00, 32'h3, 4'hF, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL busy_ctrl_err got=%b want=1", e); end
        total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL busy_no_restart got=%b want=0", eng_start); end
        rd(5'h04, d, e);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL busy_status got=%h want=1", d); end
        rd(5'h08, d, e);
        total++; if (d !== 32'h00220044) begin bad++; $display("FAIL busy_din0_kept got=%h want=00220044", d); end
        eng_done = 1'b1; eng_dout = 64'hDEADBEEF_CAFEF00D;
        step();
        eng_done = 1'b0; eng_dout = '0;
        rd(5'h18, d, e);
        total++; if (d !== 32'd5) begin bad++; $display("FAIL busy_cycles got=%0d want=5", d); end
        rd(5'h00, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL busy_irq_en_kept got=%h want=0", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL busy_irq got=%b want=0", irq); end
        wr(5'h10, 32'h12345678, 4'hF, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL wr_dout0_err got=%b want=1", e); end
        rd(5'h10, d, e);
        total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL dout0_unwritten got=%h want=cafef00d", d); end
        rd(5'h1C, d, e);
        total++; if (d !== 32'd0 || e !== 1'b1) begin bad++; $display("FAIL rd_1c got=%h err=%b want=0 err=1", d, e); end
    endtask

    task automatic test_done_on_timeout();
        logic e;
        logic [31:0] d;
        wr(5'h00, 32'h1, 4'hF, e);
        for (int k = 0; k < 7; k++) step();
        eng_done = 1'b1; eng_dout = 64'h0;
        #1;
        total++; if (eng_abort !== 1'b0) begin bad++; $display("FAIL coinc_abort_now got=%b want=0", eng_abort); end
        step();
        eng_done = 1'b0;
        total++; if (eng_abort !== 1'b0) begin bad++; $display("FAIL coinc_abort_next got=%b want=0", eng_abort); end
        rd(5'h04, d, e);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL coinc_status got=%h want=2", d); end
        rd(5'h18, d, e);
        total++; if (d !== 32'd8) begin bad++; $display("FAIL coinc_cycles got=%0d want=8", d); end
    endtask

    task automatic test_w1c_vs_set();
        logic e;
        logic [31:0] d;
        wr(5'h00, 32'h3, 4'hF, e);
        step();
        eng_done = 1'b1; eng_dout = 64'h1;
        wr(5'h04, 32'h2, 4'h1, e);
        eng_done = 1'b0;
        rd(5'h04, d, e);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL w1c_set_wins got=%h want=2", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq got=%b want=1", irq); end
        wr(5'h04, 32'h6, 4'h2, e);
        rd(5'h04, d, e);
        total++; if (d !== 32'h2 || e !== 1'b0) begin bad++; $display("FAIL w1c_no_lane0 got=%h want=2", d); end
        wr(5'h04, 32'h2, 4'h1, e);
        rd(5'h04, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_clear got=%h want=0", d); end
    endtask

    initial begin
        test_reset();
        test_din();
        test_operation();
        test_timeout();
        test_busy_reject();
        test_done_on_timeout();
        test_w1c_vs_set();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/crypto_csr_ctrl.md
# crypto_csr_ctrl

Control/status register block and engine sequencer for the crypto coprocessor. It sits behind the AXI-lite slave adapter's local read/write channels and decodes a 5-bit word-aligned register map. It launches one operation at a time on the crypto engine, supervises completion with a timeout, and captures the result. It also raises a level interrupt.

## Interface
- TIMEOUT_CYCLES, 1024: maximum RUN cycles before abort; legal range 2..65535.
- s_axi_aclk  in  1  clock, rising edge.
- s_axi_aresetn  in  1  reset; asynchronous, active-low.
- write  in  1  local write request, held until write_done.
- write_addrs  in  5  byte address; bits [1:0] ignored.
- write_data  in  32  write data.
- write_strobe  in  4  byte enables.
- write_error  out  1  write rejected, valid with write_done.
- write_done  out  1  write completes this cycle.
- read  in  1  local read request.
- read_addrs  in  5  byte address; bits [1:0] ignored.
- read_data  out  32  read data, valid with read_done.
- read_error  out  1  read rejected, valid with read_done.
- read_done  out  1  read completes this cycle.
- eng_start  out  1  one-cycle launch pulse.
- eng_abort  out  1  one-cycle abort pulse on timeout.
- eng_din  out  64  {DIN1,DIN0}, driven continuously.
- eng_done  in  1  one-cycle completion pulse.
- eng_dout  in  64  result, valid with eng_done.
- irq  out  1  level interrupt.

## Operation
Register map:
- 0x00 CTRL RW: bit0 START, write-1 launches and reads 0; bit1 IRQ_EN.
- 0x04 STATUS: bit0 BUSY RO; bit1 DONE, sticky, W1C; bit2 TIMEOUT, sticky, W1C.
- 0x08 DIN0 RW. 0x0C DIN1 RW. Both honor write_strobe per byte.
- 0x10 DOUT0 RO. 0x14 DOUT1 RO.
- 0x18 CYCLES RO: [15:0] RUN cycle count of the last operation.
- 0x1C unmapped.

Local bus:
- Zero wait states: write_done = write; read_done = read (combinational).
- A write commits on the clock edge where write & write_done.
- A write is rejected with write_error=1 and has no effect when it targets DOUT0, DOUT1, CYCLES or 0x1C.
- A write is also rejected when it targets DIN0, DIN1, or CTRL with START=1 while BUSY.
- A rejected CTRL write while BUSY does not update IRQ_EN either.
- CTRL, STATUS W1C and IRQ_EN fields use byte lane 0 only. If strobe[0]=0, the write succeeds with no effect.
- Reads of 0x1C return read_data=0 and read_error=1. Unused bits read 0.

Sequencer states: IDLE, RUN, ABORT.
- IDLE -> RUN on an accepted START write. Clear CYCLES and the DONE and TIMEOUT bits.
- RUN: counter increments each cycle and saturates at 0xFFFF.
- RUN with eng_done -> IDLE. Capture eng_dout into DOUT1:DOUT0 and set DONE.
- RUN with counter = TIMEOUT_CYCLES-1 and no eng_done -> ABORT.
- ABORT lasts one cycle. eng_abort=1, set TIMEOUT and DONE, DOUT unchanged, -> IDLE.
- BUSY = (state != IDLE).
- irq = IRQ_EN & DONE.

Boundary rules:
- eng_done outside RUN is ignored.
- eng_done on the timeout cycle: completion wins, no abort.
- A W1C of DONE coinciding with a hardware set: the set wins.
- Reset mid-RUN: return to IDLE immediately. No eng_abort is issued.

## Timing
- Reset values: all registers 0, state IDLE. eng_start, eng_abort and irq are 0. eng_din is 0.
- START accepted at edge N: eng_start=1 in cycle N+1 only, and BUSY reads 1 from cycle N+1.
- eng_done in cycle M: at edge M the state becomes IDLE and DONE sets. STATUS and DOUT reflect this from cycle M+1.
- CYCLES = number of RUN cycles, counting the eng_start cycle as 1 through the eng_done cycle.
- Timeout: ABORT is entered TIMEOUT_CYCLES cycles after the eng_start cycle. eng_abort is high that cycle, and IDLE follows.
- Write and read on the same cycle are independent. A read of STATUS in the START edge cycle returns the pre-edge value.

## Test plan
- Reset with s_axi_aresetn=0 asynchronously mid-cycle -> all outputs 0 immediately, all registers read 0.
- Write DIN0=0x11223344 (strobe 4'b0101), then DIN1=0xAABBCCDD (strobe 4'hF) -> eng_din=0xAABBCCDD_00220044.
- Write CTRL=0x3, eng_done 5 cycles after eng_start with eng_dout=0x0123456789ABCDEF -> DOUT0=0x89ABCDEF, DOUT1=0x01234567, STATUS=0x2, CYCLES=6, irq=1. Write STATUS=0x2 -> irq=0.
- Start with no eng_done, TIMEOUT_CYCLES=8 -> eng_abort on the 8th cycle after eng_start, STATUS=0x6, DOUT unchanged.
- While BUSY, write DIN0 and CTRL=0x1 -> write_error=1 both times, no second eng_start, DIN0 unchanged. Write to 0x10 -> write_error=1. Read 0x1C -> read_error=1, data 0.
- eng_done coincident with timeout cycle -> no eng_abort, STATUS=0x2. W1C of DONE coincident with eng_done -> DONE remains 1.
